// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, defaults and helpers for the byte-serial memory arbiter
package mem_pkg;

  localparam int MEM_ADDR_WIDTH   = 17;
  localparam int MEM_STARVE_LIMIT = 4;

  typedef enum logic [2:0] {
    SZ_BYTE_S = 3'b000,
    SZ_HALF_S = 3'b001,
    SZ_WORD   = 3'b010,
    SZ_BYTE_U = 3'b100,
    SZ_HALF_U = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of RAM byte beats for a size code; reserved codes do no RAM access.
  function automatic logic [2:0] beat_count(input logic [2:0] size);
    case (size)
      SZ_BYTE_S, SZ_BYTE_U: beat_count = 3'd1;
      SZ_HALF_S, SZ_HALF_U: beat_count = 3'd2;
      SZ_WORD:              beat_count = 3'd4;
      default:              beat_count = 3'd0;
    endcase
  endfunction

  // Sign- or zero-extend the assembled load bytes according to the size code.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] size);
    case (size)
      SZ_BYTE_S: extend_load = {{24{raw[7]}}, raw[7:0]};
      SZ_BYTE_U: extend_load = {24'h0, raw[7:0]};
      SZ_HALF_S: extend_load = {{16{raw[15]}}, raw[15:0]};
      SZ_HALF_U: extend_load = {16'h0, raw[15:0]};
      SZ_WORD:   extend_load = raw;
      default:   extend_load = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester ports and byte-wide RAM port of the memory arbiter
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [2:0]            size0;
  logic [2:0]            size1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [31:0]           wdata0;
  logic [31:0]           wdata1;
  logic                  done0;
  logic                  done1;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;

  modport master (
    output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  done0, done1, rdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output done0, done1, rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - port-0 priority pick with a starvation escape for port 1
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_en,
  output logic o_grant1
);
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starve;
  logic          w_starved;

  assign w_starved = (r_starve == CW'(STARVE_LIMIT));
  assign o_grant1  = i_req1 & (~i_req0 | w_starved);

  // Count port-0 wins over a waiting port 1; any other grant resets the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (i_en) begin
      if (!o_grant1 && i_req1) begin
        if (!w_starved) r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sequencing sized accesses onto a byte-wide RAM
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BEAT = ST_BEAT;
  localparam logic [1:0] LAST = ST_LAST;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]            r_state;
  logic                  r_port;
  logic                  r_we;
  logic [2:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_nbeats;
  logic [2:0]            r_beat;
  logic                  r_cap_pend;
  logic [1:0]            r_cap_lane;
  logic [31:0]           r_rbuf;
  logic                  r_done0;
  logic                  r_done1;
  logic [31:0]           r_rdata;

  logic                  w_any_req;
  logic                  w_arb_en;
  logic                  w_grant1;
  logic                  w_sel_we;
  logic [2:0]            w_sel_size;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [2:0]            w_sel_nbeats;
  logic                  w_in_beat;
  logic [31:0]           w_rbuf_next;

  assign w_any_req = bus.req0 | bus.req1;
  assign w_arb_en  = (r_state == IDLE) & w_any_req;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req0   (bus.req0),
    .i_req1   (bus.req1),
    .i_en     (w_arb_en),
    .o_grant1 (w_grant1)
  );

  assign w_sel_we     = w_grant1 ? bus.we1    : bus.we0;
  assign w_sel_size   = w_grant1 ? bus.size1  : bus.size0;
  assign w_sel_addr   = w_grant1 ? bus.addr1  : bus.addr0;
  assign w_sel_wdata  = w_grant1 ? bus.wdata1 : bus.wdata0;
  assign w_sel_nbeats = beat_count(w_sel_size);

  // RAM port is only active during beats; address wraps naturally at ADDR_WIDTH.
  assign w_in_beat     = (r_state == BEAT);
  assign bus.mem_addr  = w_in_beat ? (r_addr + ADDR_WIDTH'(r_beat)) : '0;
  assign bus.mem_we    = w_in_beat & r_we;
  assign bus.mem_wdata = (w_in_beat & r_we) ? r_wdata[{r_beat[1:0], 3'b000} +: 8] : 8'h00;

  assign bus.done0 = r_done0;
  assign bus.done1 = r_done1;
  assign bus.rdata = r_rdata;

  // Merge the RAM byte that arrived for the previous beat into its lane.
  always_comb begin
    w_rbuf_next = r_rbuf;
    if (r_cap_pend) w_rbuf_next[{r_cap_lane, 3'b000} +: 8] = bus.mem_rdata;
  end

  // Access sequencer: latch the winner, walk the beats, capture load bytes, report done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_nbeats   <= 3'd0;
      r_beat     <= 3'd0;
      r_cap_pend <= 1'b0;
      r_cap_lane <= 2'd0;
      r_rbuf     <= 32'h0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cap_pend <= 1'b0;
          if (w_any_req) begin
            r_port   <= w_grant1;
            r_we     <= w_sel_we;
            r_size   <= w_sel_size;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_nbeats <= w_sel_nbeats;
            r_beat   <= 3'd0;
            r_rbuf   <= 32'h0;
            r_state  <= (w_sel_nbeats == 3'd0) ? LAST : BEAT;
          end
        end
        BEAT: begin
          r_rbuf     <= w_rbuf_next;
          r_cap_pend <= ~r_we;
          r_cap_lane <= r_beat[1:0];
          if (r_beat == r_nbeats - 3'd1) begin
            r_state <= LAST;
          end else begin
            r_beat <= r_beat + 3'd1;
          end
        end
        LAST: begin
          r_rbuf     <= w_rbuf_next;
          r_cap_pend <= 1'b0;
          r_rdata    <= r_we ? 32'h0 : extend_load(w_rbuf_next, r_size);
          r_done0    <= ~r_port;
          r_done1    <= r_port;
          r_state    <= DONE;
        end
        DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_rdata <= 32'h0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte-wide synchronous RAM
module tb_mem_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    int          cyc;
  } exp_done_t;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  exp_done_t q_done[$];
  exp_wr_t   q_wr[$];
  exp_done_t md;
  exp_wr_t   mw;

  logic [7:0] ram [0:(1<<17)-1];

  mem_arbiter_if #(.ADDR_WIDTH(17)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH   (17),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbeats(input logic [2:0] size);
    case (size)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (q_wr.size() == 0) begin
        check_eq("unexpected_write", {47'h0, bus.mem_addr}, 64'h1ffff_ffff);
      end else begin
        mw = q_wr.pop_front();
        check_eq("wr_addr", bus.mem_addr, mw.addr);
        check_eq("wr_data", bus.mem_wdata, mw.data);
        check_eq("wr_cycle", cyc, mw.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.done0 || bus.done1) begin
      if (q_done.size() == 0) begin
        check_eq("unexpected_done", {bus.done1, bus.done0}, 2'b00);
      end else begin
        md = q_done.pop_front();
        check_eq("done_port", {bus.done1, bus.done0}, md.port ? 2'b10 : 2'b01);
        check_eq("done_rdata", bus.rdata, md.rdata);
        check_eq("done_cycle", cyc, md.cyc);
      end
    end
  end

  task automatic drive_req(input logic port, input logic we, input logic [2:0] size,
                           input logic [16:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.size1 = size; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.size0 = size; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic push_writes(input logic [16:0] addr, input logic [31:0] wdata, input int n, input int t);
    exp_wr_t w;
    for (int k = 0; k < n; k++) begin
      w.addr = addr + 17'(k);
      w.data = wdata[8*k +: 8];
      w.cyc  = t + k;
      q_wr.push_back(w);
    end
  endtask

  task automatic wait_done(input int budget);
    int to;
    to = 0;
    while (q_done.size() != 0 && to < budget) begin
      @(negedge clk);
      to++;
    end
    if (q_done.size() != 0) begin
      check_eq("done_timeout", q_done.size(), 0);
      q_done.delete();
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
  task automatic do_access(input logic port, input logic we, input logic [2:0] size,
                           input logic [16:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata);
    int n, t;
    exp_done_t d;
    n = nbeats(size);
    drive_req(port, we, size, addr, wdata);
    t = cyc + 1;
    if (we) push_writes(addr, wdata, n, t);
    d.port  = port;
    d.rdata = we ? 32'h0 : exp_rdata;
    d.cyc   = t + n + 1;
    q_done.push_back(d);
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done(20);
    @(negedge clk);
    check_eq("writes_left", q_wr.size(), 0);
    q_wr.delete();
  endtask

  task automatic starve_test();
    int t0;
    exp_done_t d;
    drive_req(1'b0, 1'b0, 3'b000, 17'h00040, 32'h0);
    drive_req(1'b1, 1'b0, 3'b000, 17'h00041, 32'h0);
    t0 = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      d.port  = ((k % 5) == 4);
      d.rdata = d.port ? 32'h22 : 32'h11;
      d.cyc   = t0 + 4 * k + 2;
      q_done.push_back(d);
    end
    wait_done(60);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_mid_store();
    int t;
    drive_req(1'b0, 1'b1, 3'b010, 17'h00100, 32'h11223344);
    t = cyc + 1;
    push_writes(17'h00100, 32'h11223344, 2, t);
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_mem_we", bus.mem_we, 1'b0);
    check_eq("abort_done", {bus.done1, bus.done0}, 2'b00);
    check_eq("abort_rdata", bus.rdata, 32'h0);
    check_eq("abort_mem_addr", bus.mem_addr, 17'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("abort_writes_left", q_wr.size(), 0);
    q_wr.delete();
    check_eq("abort_ram0", ram[17'h00100], 8'h44);
    check_eq("abort_ram1", ram[17'h00101], 8'h33);
    check_eq("abort_ram2", ram[17'h00102], 8'h00);
    check_eq("abort_ram3", ram[17'h00103], 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < (1 << 17); i++) ram[i] = 8'h00;
    ram[17'h00010] = 8'h80;
    ram[17'h00020] = 8'h34;
    ram[17'h00021] = 8'hF2;
    ram[17'h00040] = 8'h11;
    ram[17'h00041] = 8'h22;
    bus.req0 = 1'b0;   bus.req1 = 1'b0;
    bus.we0 = 1'b0;    bus.we1 = 1'b0;
    bus.size0 = 3'b0;  bus.size1 = 3'b0;
    bus.addr0 = '0;    bus.addr1 = '0;
    bus.wdata0 = '0;   bus.wdata1 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done0", bus.done0, 1'b0);
    check_eq("rst_done1", bus.done1, 1'b0);
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    check_eq("rst_rdata", bus.rdata, 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 17'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(1'b0, 1'b1, 3'b010, 17'h10000, 32'hDEADBEEF, 32'h0);
    do_access(1'b1, 1'b0, 3'b000, 17'h00010, 32'h0, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b100, 17'h00010, 32'h0, 32'h00000080);
    do_access(1'b1, 1'b0, 3'b010, 17'h10000, 32'h0, 32'hDEADBEEF);
    do_access(1'b0, 1'b0, 3'b001, 17'h00020, 32'h0, 32'hFFFFF234);
    do_access(1'b0, 1'b0, 3'b101, 17'h00020, 32'h0, 32'h0000F234);
    do_access(1'b0, 1'b1, 3'b001, 17'h1FFFF, 32'h0000A55A, 32'h0);
    check_eq("wrap_lo", ram[17'h1FFFF], 8'h5A);
    check_eq("wrap_hi", ram[17'h00000], 8'hA5);
    do_access(1'b1, 1'b0, 3'b101, 17'h1FFFF, 32'h0, 32'h0000A55A);
    do_access(1'b1, 1'b1, 3'b100, 17'h00030, 32'h12345677, 32'h0);
    check_eq("ubyte_store", ram[17'h00031], 8'h00);
    do_access(1'b0, 1'b0, 3'b011, 17'h00010, 32'h0, 32'h0);
    do_access(1'b1, 1'b1, 3'b011, 17'h00050, 32'hCAFEF00D, 32'h0);
    check_eq("nop_store_ram", ram[17'h00050], 8'h00);
    starve_test();
    reset_mid_store();
    do_access(1'b0, 1'b0, 3'b000, 17'h00100, 32'h0, 32'h00000044);

    repeat (3) @(negedge clk);
    check_eq("done_queue_empty", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
